// File: rtl/bp_fe_icache_arbiter.sv
// bp_fe_icache_arbiter: shares the FE I$ request port between demand fetches
// and a one-entry next-line prefetch buffer. Demand always wins with zero
// latency. A buffered prefetch goes out only in idle I$ cycles. It is dropped
// when it ages out, when it becomes redundant, and around redirects and fences.
//
// Ports:
//   clk_i, reset_i       clock, async active-high reset
//   demand_v_i/pkt_i     demand fetch packet {vaddr, op, spec}
//   demand_force_i       demand is a redirect/command fetch
//   demand_yumi_o        demand consumed by the I$
//   flush_i              redirect; drops the prefetch state
//   pf_v_i/pf_vaddr_i    prefetch address; pf_ready_o = buffer can accept
//   icache_v_o/pkt_o     request to the I$; icache_yumi_i = consumed
//   pf_issued_o          pulse when a prefetch is consumed
//   pf_dropped_o         pulse when a buffered prefetch is discarded
//
// Build option BP_FE_ICACHE_ARB_PREFETCH_EN: when defined, the prefetch buffer,
// its aging and the fence FSM are built. When undefined, the block is a plain
// demand passthrough and all prefetch outputs are tied low.

module bp_fe_icache_arbiter #(
    parameter int  vaddr_width_p        = 39,
    parameter int  icache_block_width_p = 512,
    parameter int  pf_timeout_p         = 15,
    localparam int icache_op_width_lp   = 2,
    localparam int icache_pkt_width_lp  = vaddr_width_p + icache_op_width_lp + 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           demand_v_i,
    input  logic [icache_pkt_width_lp-1:0] demand_pkt_i,
    input  logic                           demand_force_i,
    output logic                           demand_yumi_o,
    input  logic                           flush_i,
    input  logic                           pf_v_i,
    input  logic [vaddr_width_p-1:0]       pf_vaddr_i,
    output logic                           pf_ready_o,
    output logic                           icache_v_o,
    output logic [icache_pkt_width_lp-1:0] icache_pkt_o,
    input  logic                           icache_yumi_i,
    output logic                           pf_issued_o,
    output logic                           pf_dropped_o
);

`ifdef BP_FE_ICACHE_ARB_PREFETCH_EN

    localparam int offset_width_lp = $clog2(icache_block_width_p / 8);
    localparam int age_width_lp    = $clog2(pf_timeout_p + 1);

    localparam logic [vaddr_width_p-1:0] line_mask_lp =
        {vaddr_width_p{1'b1}} << offset_width_lp;
    localparam logic [age_width_lp-1:0] age_max_lp = age_width_lp'(pf_timeout_p);

    localparam logic [icache_op_width_lp-1:0] e_icache_fetch  = 2'd0;
    localparam logic [icache_op_width_lp-1:0] e_icache_fencei = 2'd1;

    typedef enum logic {
        e_run         = 1'b0,
        e_fence_block = 1'b1
    } state_e;

    state_e state_r, state_n;

    logic                      pf_v_r;
    logic [vaddr_width_p-1:0]  pf_line_r;
    logic [age_width_lp-1:0]   age_r;

    logic [vaddr_width_p-1:0]      demand_vaddr;
    logic [icache_op_width_lp-1:0] demand_op;
    logic demand_accept, pf_grant, pf_issue, pf_enq, pf_drop;
    logic fence_accept, redundant, aged;

    assign demand_vaddr = demand_pkt_i[icache_pkt_width_lp-1 -: vaddr_width_p];
    assign demand_op    = demand_pkt_i[1 +: icache_op_width_lp];

    assign demand_accept = demand_v_i & icache_yumi_i;
    assign pf_grant      = ~demand_v_i & pf_v_r & (state_r == e_run);
    assign pf_issue      = pf_grant & icache_yumi_i;

    assign fence_accept = demand_accept & (demand_op == e_icache_fencei)
                        & (state_r == e_run);
    assign redundant    = demand_accept
                        & ((demand_vaddr & line_mask_lp) == pf_line_r);
    assign aged         = (age_r == age_max_lp);

    // Issue wins over every drop cause, so the two pulses are exclusive.
    assign pf_drop = pf_v_r & ~pf_issue
                   & (flush_i | (demand_force_i & demand_v_i)
                      | redundant | aged | fence_accept);

    // Held low in reset so nothing is enqueued on the release edge.
    assign pf_ready_o = ~reset_i & ~pf_v_r & (state_r == e_run) & ~flush_i;
    assign pf_enq     = pf_v_i & pf_ready_o;

    assign pf_issued_o  = pf_issue;
    assign pf_dropped_o = pf_drop;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_run;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_run: begin
                if (demand_accept && demand_op == e_icache_fencei)
                    state_n = e_fence_block;
            end
            e_fence_block: begin
                if (demand_accept && demand_op == e_icache_fetch)
                    state_n = e_run;
            end
            default: state_n = e_run;
        endcase
    end

    always_comb begin
        icache_v_o    = 1'b0;
        icache_pkt_o  = '0;
        demand_yumi_o = 1'b0;
        if (demand_v_i) begin
            icache_v_o    = 1'b1;
            icache_pkt_o  = demand_pkt_i;
            demand_yumi_o = icache_yumi_i;
        end else if (pf_grant) begin
            icache_v_o   = 1'b1;
            icache_pkt_o = {pf_line_r, e_icache_fetch, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pf_v_r    <= 1'b0;
            pf_line_r <= '0;
            age_r     <= '0;
        end else if (pf_enq) begin
            pf_v_r    <= 1'b1;
            pf_line_r <= pf_vaddr_i & line_mask_lp;
            age_r     <= '0;
        end else if (pf_issue || pf_drop) begin
            pf_v_r <= 1'b0;
        end else if (pf_v_r && !aged) begin
            age_r <= age_r + 1'b1;
        end
    end

`else

    logic unused_inputs;

    assign unused_inputs = ^{clk_i, reset_i, demand_force_i, flush_i,
                             pf_v_i, pf_vaddr_i}
                         | (pf_timeout_p == 0) | (icache_block_width_p == 0);

    assign icache_v_o    = demand_v_i;
    assign icache_pkt_o  = demand_v_i ? demand_pkt_i : '0;
    assign demand_yumi_o = demand_v_i & icache_yumi_i;
    assign pf_ready_o    = 1'b0;
    assign pf_issued_o   = 1'b0;
    assign pf_dropped_o  = 1'b0;

`endif

endmodule

// File: tb/tb_bp_fe_icache_arbiter.sv
// Testbench for bp_fe_icache_arbiter: directed scenarios plus a randomized
// run against a behavioural model of the arbitration rules.

module tb_bp_fe_icache_arbiter;

    localparam int VW = 39;
    localparam int PW = VW + 3;
    localparam int T  = 3;
    localparam logic [1:0] OP_FETCH  = 2'd0;
    localparam logic [1:0] OP_FENCEI = 2'd1;
    localparam logic [VW-1:0] LMASK  = ~39'h3f;

`ifdef BP_FE_ICACHE_ARB_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          demand_v_i = 1'b0;
    logic [PW-1:0] demand_pkt_i = '0;
    logic          demand_force_i = 1'b0;
    logic          demand_yumi_o;
    logic          flush_i = 1'b0;
    logic          pf_v_i = 1'b0;
    logic [VW-1:0] pf_vaddr_i = '0;
    logic          pf_ready_o;
    logic          icache_v_o;
    logic [PW-1:0] icache_pkt_o;
    logic          icache_yumi_i = 1'b0;
    logic          pf_issued_o;
    logic          pf_dropped_o;

    int tests = 0;
    int fails = 0;

    bit            m_pf_v, m_fence;
    logic [VW-1:0] m_line;
    int            m_age;

    logic          e_v, e_dyumi, e_ready, e_issued, e_dropped;
    logic [PW-1:0] e_pkt;

    bp_fe_icache_arbiter #(
        .vaddr_width_p       (VW),
        .icache_block_width_p(512),
        .pf_timeout_p        (T)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .demand_v_i    (demand_v_i),
        .demand_pkt_i  (demand_pkt_i),
        .demand_force_i(demand_force_i),
        .demand_yumi_o (demand_yumi_o),
        .flush_i       (flush_i),
        .pf_v_i        (pf_v_i),
        .pf_vaddr_i    (pf_vaddr_i),
        .pf_ready_o    (pf_ready_o),
        .icache_v_o    (icache_v_o),
        .icache_pkt_o  (icache_pkt_o),
        .icache_yumi_i (icache_yumi_i),
        .pf_issued_o   (pf_issued_o),
        .pf_dropped_o  (pf_dropped_o)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mk_pkt(input logic [VW-1:0] va,
                                             input logic [1:0] op,
                                             input logic sp);
        return {va, op, sp};
    endfunction

    task automatic drive(input bit dv, input logic [VW-1:0] dva,
                         input logic [1:0] dop, input bit frc, input bit fl,
                         input bit pv, input logic [VW-1:0] pva, input bit y);
        demand_v_i     = dv;
        demand_pkt_i   = mk_pkt(dva, dop, 1'b0);
        demand_force_i = frc;
        flush_i        = fl;
        pf_v_i         = pv;
        pf_vaddr_i     = pva;
        icache_yumi_i  = y;
    endtask

    task automatic idle();
        drive(0, '0, OP_FETCH, 0, 0, 0, '0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        m_pf_v  = 0;
        m_fence = 0;
        m_line  = '0;
        m_age   = 0;
    endtask

    task automatic model_comb();
        logic [VW-1:0] dva;
        logic [1:0]    dop;
        bit vis, acc, cause;
        dva = demand_pkt_i[PW-1 -: VW];
        dop = demand_pkt_i[2:1];
        vis = PF_EN && m_pf_v && !m_fence && !demand_v_i;
        e_v = demand_v_i || vis;
        e_pkt = demand_v_i ? demand_pkt_i
              : (vis ? mk_pkt(m_line, OP_FETCH, 1'b1) : '0);
        e_dyumi  = demand_v_i && icache_yumi_i;
        e_issued = vis && icache_yumi_i;
        acc = e_dyumi;
        cause = flush_i || (demand_force_i && demand_v_i)
             || (acc && ((dva & LMASK) == m_line)) || (m_age >= T)
             || (acc && dop == OP_FENCEI && !m_fence);
        e_dropped = PF_EN && m_pf_v && !e_issued && cause;
        e_ready = PF_EN && !m_pf_v && !m_fence && !flush_i && !reset_i;
    endtask

    task automatic model_step();
        logic [1:0] dop;
        dop = demand_pkt_i[2:1];
        if (!PF_EN) return;
        if (pf_v_i && e_ready) begin
            m_pf_v = 1;
            m_line = pf_vaddr_i & LMASK;
            m_age  = 0;
        end else if (e_issued || e_dropped) begin
            m_pf_v = 0;
        end else if (m_pf_v) begin
            m_age = (m_age + 1 > T) ? T : m_age + 1;
        end
        if (e_dyumi) begin
            if (!m_fence && dop == OP_FENCEI) m_fence = 1;
            else if (m_fence && dop == OP_FETCH) m_fence = 0;
        end
    endtask

    task automatic test_reset();
        #1 reset_i = 1'b1;
        #1;
        tests++;
        if ({icache_v_o, pf_ready_o, pf_issued_o, pf_dropped_o} !== 4'b0) begin
            fails++;
            $display("FAIL reset_outs: got %b want 0000",
                     {icache_v_o, pf_ready_o, pf_issued_o, pf_dropped_o});
        end
        drive(1, 39'h3000, OP_FETCH, 0, 0, 1, 39'h3040, 1);
        #1;
        tests++;
        if (icache_pkt_o !== mk_pkt(39'h3000, OP_FETCH, 1'b0)
            || {icache_v_o, demand_yumi_o, pf_ready_o} !== 3'b110) begin
            fails++;
            $display("FAIL reset_demand: got %h/%b want %h/110", icache_pkt_o,
                     {icache_v_o, demand_yumi_o, pf_ready_o},
                     mk_pkt(39'h3000, OP_FETCH, 1'b0));
        end
        idle();
        tick();
        reset_i = 1'b0;
        #1;
        tests++;
        if (pf_ready_o !== PF_EN) begin
            fails++;
            $display("FAIL post_reset_ready: got %b want %b", pf_ready_o, PF_EN);
        end
        tick();
    endtask

`ifdef BP_FE_ICACHE_ARB_PREFETCH_EN
    task automatic test_idle_prefetch();
        do_reset();
        drive(0, '0, OP_FETCH, 0, 0, 1, 39'h8000_1034, 0);
        #1;
        tests++;
        if (pf_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL idle_ready: got %b want 1", pf_ready_o);
        end
        tick();
        drive(0, '0, OP_FETCH, 0, 0, 0, '0, 1);
        #1;
        tests++;
        if ({icache_v_o, pf_issued_o, pf_dropped_o} !== 3'b110
            || icache_pkt_o !== mk_pkt(39'h8000_1000, OP_FETCH, 1'b1)) begin
            fails++;
            $display("FAIL idle_issue: got %b/%h want 110/%h",
                     {icache_v_o, pf_issued_o, pf_dropped_o}, icache_pkt_o,
                     mk_pkt(39'h8000_1000, OP_FETCH, 1'b1));
        end
        tick();
        idle();
        #1;
        tests++;
        if ({pf_ready_o, icache_v_o} !== 2'b10) begin
            fails++;
            $display("FAIL idle_after: got %b want 10", {pf_ready_o, icache_v_o});
        end
    endtask

    task automatic test_demand_preempt();
        do_reset();
        drive(0, '0, OP_FETCH, 0, 0, 1, 39'h1040, 0);
        tick();
        drive(1, 39'h2000, OP_FETCH, 0, 0, 0, '0, 1);
        #1;
        tests++;
        if (icache_pkt_o !== mk_pkt(39'h2000, OP_FETCH, 1'b0)
            || {demand_yumi_o, pf_issued_o, pf_dropped_o} !== 3'b100) begin
            fails++;
            $display("FAIL preempt_demand: got %h/%b want %h/100", icache_pkt_o,
                     {demand_yumi_o, pf_issued_o, pf_dropped_o},
                     mk_pkt(39'h2000, OP_FETCH, 1'b0));
        end
        tick();
        idle();
        #1;
        tests++;
        if (icache_v_o !== 1'b1
            || icache_pkt_o !== mk_pkt(39'h1040, OP_FETCH, 1'b1)) begin
            fails++;
            $display("FAIL preempt_kept: got %b/%h want 1/%h", icache_v_o,
                     icache_pkt_o, mk_pkt(39'h1040, OP_FETCH, 1'b1));
        end
    endtask

    task automatic test_redundant();
        do_reset();
        drive(0, '0, OP_FETCH, 0, 0, 1, 39'h4000, 0);
        tick();
        drive(1, 39'h4008, OP_FETCH, 0, 0, 0, '0, 1);
        #1;
        tests++;
        if ({pf_dropped_o, pf_issued_o} !== 2'b10) begin
            fails++;
            $display("FAIL redundant_drop: got %b want 10",
                     {pf_dropped_o, pf_issued_o});
        end
        tick();
        drive(0, '0, OP_FETCH, 0, 0, 0, '0, 1);
        #1;
        tests++;
        if ({icache_v_o, pf_issued_o, pf_ready_o} !== 3'b001) begin
            fails++;
            $display("FAIL redundant_after: got %b want 001",
                     {icache_v_o, pf_issued_o, pf_ready_o});
        end
    endtask

    task automatic test_aging();
        do_reset();
        drive(1, 39'h9000, OP_FETCH, 0, 0, 1, 39'h5000, 0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            drive(1, 39'h9000, OP_FETCH, 0, 0, 0, '0, 0);
            #1;
            tests++;
            if (pf_dropped_o !== (c == 4)) begin
                fails++;
                $display("FAIL aging_c%0d: got %b want %b", c, pf_dropped_o,
                         c == 4);
            end
            tick();
        end
        idle();
        #1;
        tests++;
        if ({pf_ready_o, icache_v_o} !== 2'b10) begin
            fails++;
            $display("FAIL aging_after: got %b want 10", {pf_ready_o, icache_v_o});
        end
    endtask

    task automatic test_fence();
        do_reset();
        drive(0, '0, OP_FETCH, 0, 0, 1, 39'h6000, 0);
        tick();
        drive(1, 39'h6100, OP_FENCEI, 0, 0, 0, '0, 1);
        #1;
        tests++;
        if ({pf_dropped_o, pf_ready_o} !== 2'b10) begin
            fails++;
            $display("FAIL fence_drop: got %b want 10", {pf_dropped_o, pf_ready_o});
        end
        tick();
        drive(0, '0, OP_FETCH, 0, 1, 1, 39'h6200, 1);
        #1;
        tests++;
        if ({pf_ready_o, icache_v_o} !== 2'b00) begin
            fails++;
            $display("FAIL fence_block: got %b want 00", {pf_ready_o, icache_v_o});
        end
        tick();
        drive(1, 39'h6300, OP_FETCH, 0, 0, 1, 39'h6200, 0);
        #1;
        tests++;
        if (pf_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL fence_noacc: got %b want 0", pf_ready_o);
        end
        tick();
        drive(1, 39'h6300, OP_FETCH, 0, 0, 1, 39'h6200, 1);
        #1;
        tests++;
        if ({pf_ready_o, demand_yumi_o} !== 2'b01) begin
            fails++;
            $display("FAIL fence_exit: got %b want 01", {pf_ready_o, demand_yumi_o});
        end
        tick();
        drive(0, '0, OP_FETCH, 0, 0, 1, 39'h6200, 0);
        #1;
        tests++;
        if (pf_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL fence_ready: got %b want 1", pf_ready_o);
        end
        tick();
        idle();
        #1;
        tests++;
        if (icache_pkt_o !== mk_pkt(39'h6200, OP_FETCH, 1'b1)) begin
            fails++;
            $display("FAIL fence_refill: got %h want %h", icache_pkt_o,
                     mk_pkt(39'h6200, OP_FETCH, 1'b1));
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(0, '0, OP_FETCH, 0, 0, 1, 39'h7000, 0);
        tick();
        idle();
        #1;
        tests++;
        if (icache_v_o !== 1'b1) begin
            fails++;
            $display("FAIL areset_pre: got %b want 1", icache_v_o);
        end
        #1 reset_i = 1'b1;
        #1;
        tests++;
        if ({icache_v_o, pf_ready_o} !== 2'b00) begin
            fails++;
            $display("FAIL areset_now: got %b want 00", {icache_v_o, pf_ready_o});
        end
        #1 reset_i = 1'b0;
        #1;
        tests++;
        if ({icache_v_o, pf_ready_o} !== 2'b01) begin
            fails++;
            $display("FAIL areset_after: got %b want 01", {icache_v_o, pf_ready_o});
        end
        tick();
    endtask
`else
    task automatic test_pf_disabled();
        do_reset();
        drive(0, '0, OP_FETCH, 0, 0, 1, 39'h1234, 1);
        #1;
        tests++;
        if ({icache_v_o, pf_ready_o, pf_issued_o, pf_dropped_o} !== 4'b0) begin
            fails++;
            $display("FAIL nopf_outs: got %b want 0000",
                     {icache_v_o, pf_ready_o, pf_issued_o, pf_dropped_o});
        end
        tick();
        drive(1, 39'h2040, OP_FENCEI, 0, 0, 0, '0, 1);
        #1;
        tests++;
        if (icache_pkt_o !== mk_pkt(39'h2040, OP_FENCEI, 1'b0)
            || demand_yumi_o !== 1'b1) begin
            fails++;
            $display("FAIL nopf_fencei: got %h/%b want %h/1", icache_pkt_o,
                     demand_yumi_o, mk_pkt(39'h2040, OP_FENCEI, 1'b0));
        end
        tick();
        idle();
        #1;
        tests++;
        if (icache_v_o !== 1'b0) begin
            fails++;
            $display("FAIL nopf_idle: got %b want 0", icache_v_o);
        end
    endtask
`endif

    task automatic test_random();
        logic [VW-1:0] dva;
        logic [1:0]    dop;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            dva = 39'h10000 + 39'($urandom_range(0, 7) * 64 + $urandom_range(0, 63));
            dop = ($urandom_range(0, 11) == 0) ? OP_FENCEI : OP_FETCH;
            demand_v_i     = $urandom_range(0, 1) == 0;
            demand_pkt_i   = mk_pkt(dva, dop, 1'($urandom_range(0, 1)));
            demand_force_i = $urandom_range(0, 7) == 0;
            flush_i        = $urandom_range(0, 15) == 0;
            pf_v_i         = $urandom_range(0, 3) != 0;
            pf_vaddr_i     = 39'h10000
                           + 39'($urandom_range(0, 7) * 64 + $urandom_range(0, 63));
            icache_yumi_i  = $urandom_range(0, 1) == 0;
            #1;
            model_comb();
            tests++;
            if ({icache_v_o, demand_yumi_o, pf_ready_o, pf_issued_o, pf_dropped_o}
                !== {e_v, e_dyumi, e_ready, e_issued, e_dropped}) begin
                fails++;
                $display("FAIL rand_ctl[%0d]: got %b want %b", i,
                         {icache_v_o, demand_yumi_o, pf_ready_o, pf_issued_o,
                          pf_dropped_o},
                         {e_v, e_dyumi, e_ready, e_issued, e_dropped});
            end
            tests++;
            if (icache_pkt_o !== e_pkt) begin
                fails++;
                $display("FAIL rand_pkt[%0d]: got %h want %h", i, icache_pkt_o,
                         e_pkt);
            end
            model_step();
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
`ifdef BP_FE_ICACHE_ARB_PREFETCH_EN
        test_idle_prefetch();
        test_demand_preempt();
        test_redundant();
        test_aging();
        test_fence();
        test_async_reset();
`else
        test_pf_disabled();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
